// File: rtl/rpi_irq_pkg.sv
// Shared definitions for the RPi interrupt clock generator: FSM encoding,
// default divider and the irq_id width helper.
package rpi_irq_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HIGH     = 2'd1;
    localparam logic [1:0] ST_LOW      = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        HIGH     = ST_HIGH,
        LOW      = ST_LOW,
        WAIT_ACK = ST_WAIT_ACK
    } state_t;

    // 50 MHz / 64 interrupt clock rate used by the existing RPi driver.
    localparam logic [5:0] DEF_HALF_PERIOD = 6'd32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rpi_sync_edge.sv
// Two-flop synchroniser for the asynchronous RPi acknowledge, followed by a
// rising-edge detector producing a one-cycle pulse in the clk_in domain.
module rpi_sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1, sync2, sync3;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/rpi_irq_clk_gen.sv
// Interrupt clock generator: latches request edges per channel, then clocks
// the lowest pending channel out to the RPi until it acknowledges.
module rpi_irq_clk_gen
    import rpi_irq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 6,
    parameter int BURST_W = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             irq_req,
    input  logic [NUM_CH-1:0]             irq_mask,
    input  logic [DIV_W-1:0]              half_period,
    input  logic                          mode,
    input  logic [BURST_W-1:0]            burst_len,
    input  logic                          rpi_ack,
    output logic                          clk_out,
    output logic [id_width(NUM_CH)-1:0]   irq_id,
    output logic                          busy,
    output logic [NUM_CH-1:0]             overrun
);

    localparam int ID_W = id_width(NUM_CH);
    localparam logic [DIV_W-1:0]   DIV_ONE   = 1;
    localparam logic [BURST_W-1:0] BURST_ONE = 1;

    state_t             state;
    logic [NUM_CH-1:0]  req_q, pending, set_v, clr_v;
    logic               armed, ack, mode_s, ack_seen;
    logic [DIV_W-1:0]   cnt, reload, hp_eff;
    logic [BURST_W-1:0] rem, bl_eff;
    logic [ID_W-1:0]    pick;

    rpi_sync_edge u_ack_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (rpi_ack),
        .rise     (ack)
    );

    assign hp_eff = (half_period == '0) ? DIV_ONE : half_period;
    assign bl_eff = (burst_len == '0) ? BURST_ONE : burst_len;
    assign busy   = (state != IDLE);

    // armed stays low for the first edge after reset so a request already
    // held high is seen as a level, not as a fresh edge.
    assign set_v = irq_req & ~req_q & ~irq_mask & {NUM_CH{armed}};

    always_comb begin
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pending[i]) pick = i[ID_W-1:0];
    end

    always_comb begin
        clr_v = '0;
        for (int i = 0; i < NUM_CH; i++)
            clr_v[i] = ack && (state != IDLE) && (irq_id == i[ID_W-1:0]);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            armed   <= 1'b0;
            req_q   <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            armed   <= 1'b1;
            req_q   <= irq_req;
            pending <= (pending & ~clr_v) | set_v;
            overrun <= overrun | (set_v & pending);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clk_out  <= 1'b0;
            irq_id   <= '0;
            cnt      <= '0;
            reload   <= '0;
            rem      <= '0;
            mode_s   <= 1'b0;
            ack_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_seen <= 1'b0;
                    if (|pending) begin
                        irq_id  <= pick;
                        reload  <= hp_eff - DIV_ONE;
                        cnt     <= hp_eff - DIV_ONE;
                        rem     <= bl_eff;
                        mode_s  <= mode;
                        clk_out <= 1'b1;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (ack) ack_seen <= 1'b1;
                    if (cnt == '0) begin
                        cnt     <= reload;
                        rem     <= (rem != '0) ? rem - BURST_ONE : '0;
                        clk_out <= 1'b0;
                        state   <= (ack || ack_seen) ? IDLE : LOW;
                    end else begin
                        cnt <= cnt - DIV_ONE;
                    end
                end
                LOW: begin
                    if (ack) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        cnt <= reload;
                        if (mode_s && rem == '0) begin
                            state <= WAIT_ACK;
                        end else begin
                            clk_out <= 1'b1;
                            state   <= HIGH;
                        end
                    end else begin
                        cnt <= cnt - DIV_ONE;
                    end
                end
                WAIT_ACK: begin
                    if (ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
